// File: rtl/keypad_scan_ctrl_if.sv
// keypad_scan_ctrl_if: keypad pins and decode-FSM handshake around the scan controller.
interface keypad_scan_ctrl_if;
   logic [3:0] col_n_i;
   logic [3:0] row_lock_i;
   logic       row_locked_i;
   logic       tick_o;
   logic [3:0] row_drive_o;
   logic [7:0] row_col_o;
   logic [1:0] scan_state_o;
   modport master (output col_n_i, row_lock_i, row_locked_i,
                   input tick_o, row_drive_o, row_col_o, scan_state_o);
   modport slave  (input col_n_i, row_lock_i, row_locked_i,
                   output tick_o, row_drive_o, row_col_o, scan_state_o);
endinterface

// File: rtl/keypad_scan_ctrl.sv
// keypad_scan_ctrl: tick prescaler, one-hot row scan with lock parking, column conditioning.
// KEYPAD_SCAN_SYNC_EN selects a 2-flop column synchronizer instead of a single stage.
module keypad_scan_ctrl #(
   parameter int DIV_COUNT  = 50000,
   parameter int SCAN_DWELL = 2
) (
   input logic               clk,
   input logic               reset,
   keypad_scan_ctrl_if.slave kp
);
   localparam int CW = $clog2(DIV_COUNT);
   localparam int DW = SCAN_DWELL > 1 ? $clog2(SCAN_DWELL) : 1;
   typedef enum logic [1:0] {IDLE = 2'b00, SCAN = 2'b01, HOLD = 2'b10} state_t;
   state_t        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          tick_q, tick_d;
   logic [1:0]    row_idx_q, row_idx_d;
   logic [DW-1:0] dwell_q, dwell_d;
   logic [3:0]    row_drive_q, row_drive_d;
   logic [3:0]    col_act_q, col_act_d;
   logic [1:0]    lock_enc;
   logic          lock_ok;
`ifdef KEYPAD_SCAN_SYNC_EN
   logic [3:0] col_s_q;
   always_ff @(posedge clk) col_s_q <= reset ? 4'b0 : ~kp.col_n_i;
   assign col_act_d = col_s_q;
`else
   assign col_act_d = ~kp.col_n_i;
`endif
   assign lock_ok  = kp.row_lock_i != 4'b0 && (kp.row_lock_i & (kp.row_lock_i - 4'd1)) == 4'b0;
   assign lock_enc = row_drive_q[3] ? 2'd3 : row_drive_q[2] ? 2'd2 : row_drive_q[1] ? 2'd1 : 2'd0;
   always_ff @(posedge clk)
      if (reset) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         tick_q      <= 1'b0;
         row_idx_q   <= '0;
         dwell_q     <= '0;
         row_drive_q <= '0;
         col_act_q   <= '0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         tick_q      <= tick_d;
         row_idx_q   <= row_idx_d;
         dwell_q     <= dwell_d;
         row_drive_q <= row_drive_d;
         col_act_q   <= col_act_d;
      end
   always_comb begin
      tick_d      = cnt_q == CW'(DIV_COUNT - 1);
      cnt_d       = tick_d ? '0 : cnt_q + 1'b1;
      state_d     = state_q;
      row_idx_d   = row_idx_q;
      dwell_d     = dwell_q;
      row_drive_d = row_drive_q;
      if (tick_q)
         case (state_q)
            IDLE: begin
               state_d     = SCAN;
               row_idx_d   = '0;
               dwell_d     = '0;
               row_drive_d = 4'b0001;
            end
            SCAN:
               if (kp.row_locked_i) begin
                  state_d     = HOLD;
                  row_drive_d = lock_ok ? kp.row_lock_i : 4'b0;
               end else if (col_act_q == 4'b0) begin
                  // a pressed column freezes the scan so the decode FSM can evaluate it
                  row_idx_d   = dwell_q == DW'(SCAN_DWELL - 1) ? row_idx_q + 2'd1 : row_idx_q;
                  dwell_d     = dwell_q == DW'(SCAN_DWELL - 1) ? '0 : dwell_q + 1'b1;
                  row_drive_d = 4'b0001 << row_idx_d;
               end
            HOLD:
               if (!kp.row_locked_i) begin
                  state_d     = SCAN;
                  row_idx_d   = row_drive_q != 4'b0 ? lock_enc + 2'd1 : 2'd0;
                  dwell_d     = '0;
                  row_drive_d = 4'b0001 << row_idx_d;
               end else if (!lock_ok) begin
                  state_d     = SCAN;
                  row_idx_d   = '0;
                  dwell_d     = '0;
                  row_drive_d = 4'b0;
               end else
                  row_drive_d = kp.row_lock_i;
            default: state_d = IDLE;
         endcase
   end
   always_comb begin
      kp.tick_o       = tick_q;
      kp.row_drive_o  = row_drive_q;
      kp.row_col_o    = {row_drive_q, col_act_q};
      kp.scan_state_o = state_q;
   end
endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// tb_keypad_scan_ctrl: directed scan scenarios then random traffic, checked against a rule-level model.
module tb_keypad_scan_ctrl;
   localparam int DIV = 4;
   localparam int DWELL = 2;
   logic clk = 1'b0;
   logic reset = 1'b1;
   int   vectors = 0;
   int   miscompares = 0;
   int   cyc, m_tick, m_state, m_row, m_dwell;
   logic [3:0] m_drive, m_col, m_col_s;
   keypad_scan_ctrl_if kp();
   keypad_scan_ctrl #(.DIV_COUNT(DIV), .SCAN_DWELL(DWELL)) dut (.clk(clk), .reset(reset), .kp(kp));
   always #5 clk = ~clk;
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask
   task automatic scan_rules(input logic [3:0] col);
      logic [3:0] lk;
      lk = kp.row_lock_i;
      if (m_state == 0) begin
         m_state = 1; m_row = 0; m_dwell = 0; m_drive = 4'b0001;
      end else if (m_state == 1) begin
         if (kp.row_locked_i) begin
            m_state = 2;
            m_drive = $countones(lk) == 1 ? lk : 4'b0;
         end else if (col == 4'b0) begin
            if (m_dwell == DWELL - 1) begin
               m_dwell = 0;
               m_row = (m_row + 1) % 4;
            end else m_dwell++;
            m_drive = 4'(1 << m_row);
         end
      end else begin
         if (!kp.row_locked_i) begin
            m_row = m_drive != 0 ? ($clog2(m_drive) + 1) % 4 : 0;
            m_dwell = 0; m_state = 1;
            m_drive = 4'(1 << m_row);
         end else if ($countones(lk) != 1) begin
            m_state = 1; m_row = 0; m_dwell = 0; m_drive = 4'b0;
         end else m_drive = lk;
      end
   endtask
   task automatic step();
      int t;
      logic [3:0] c;
      @(posedge clk);
      if (reset) begin
         cyc = 0; m_tick = 0; m_state = 0; m_row = 0; m_dwell = 0;
         m_drive = 0; m_col = 0; m_col_s = 0;
      end else begin
         t = m_tick;
         c = m_col;
         cyc++;
         m_tick = (cyc % DIV == 0) ? 1 : 0;
`ifdef KEYPAD_SCAN_SYNC_EN
         m_col = m_col_s;
         m_col_s = ~kp.col_n_i;
`else
         m_col = ~kp.col_n_i;
`endif
         if (t != 0) scan_rules(c);
      end
      #1;
      chk("tick", 32'(kp.tick_o), 32'(m_tick));
      chk("row_drive", 32'(kp.row_drive_o), 32'(m_drive));
      chk("row_col", 32'(kp.row_col_o), 32'({m_drive, m_col}));
      chk("scan_state", 32'(kp.scan_state_o), 32'(m_state));
   endtask
   initial begin
      int n, r, sel;
      logic [3:0] seq [9];
      seq = '{4'b0001, 4'b0001, 4'b0010, 4'b0010, 4'b0100, 4'b0100, 4'b1000, 4'b1000, 4'b0001};
      kp.col_n_i = 4'hF; kp.row_lock_i = 4'b0; kp.row_locked_i = 1'b0;
      reset = 1'b1;
      step(); step();
      chk("rst_drive", 32'(kp.row_drive_o), 32'h0);
      chk("rst_state", 32'(kp.scan_state_o), 32'h0);
      chk("rst_tick", 32'(kp.tick_o), 32'h0);
      chk("rst_row_col", 32'(kp.row_col_o), 32'h0);
      reset = 1'b0;
      for (int i = 1; i <= 40; i++) begin
         step();
         if (i == 4) chk("first_tick", 32'(kp.tick_o), 32'h1);
         if (i < 4) chk("no_early_tick", 32'(kp.tick_o), 32'h0);
         if (i >= 5 && i <= 37 && (i - 5) % 4 == 0) chk("scan_seq", 32'(kp.row_drive_o), 32'(seq[(i - 5) / 4]));
      end
      n = 0;
      while (n < 40 && kp.row_drive_o !== 4'b0010) begin step(); n++; end
      chk("wait_row1", 32'(n < 40), 32'h1);
      kp.col_n_i = 4'b1101;
      for (int i = 0; i < 12; i++) step();
      chk("frozen_drive", 32'(kp.row_drive_o), 32'h2);
      chk("frozen_row_col", 32'(kp.row_col_o), 32'h22);
      kp.row_locked_i = 1'b1; kp.row_lock_i = 4'b0010;
      n = 0;
      while (n < 10 && kp.scan_state_o !== 2'b10) begin step(); n++; end
      chk("wait_hold", 32'(n < 10), 32'h1);
      chk("hold_drive", 32'(kp.row_drive_o), 32'h2);
      kp.col_n_i = 4'hF; kp.row_locked_i = 1'b0;
      n = 0;
      while (n < 10 && kp.scan_state_o !== 2'b01) begin step(); n++; end
      chk("wait_unhold", 32'(n < 10), 32'h1);
      chk("unhold_drive", 32'(kp.row_drive_o), 32'h4);
      kp.row_locked_i = 1'b1; kp.row_lock_i = 4'b0100;
      n = 0;
      while (n < 10 && kp.scan_state_o !== 2'b10) begin step(); n++; end
      chk("wait_hold2", 32'(n < 10), 32'h1);
      kp.row_lock_i = 4'b0110;
      n = 0;
      while (n < 10 && kp.scan_state_o !== 2'b01) begin step(); n++; end
      chk("wait_badlock", 32'(n < 10), 32'h1);
      chk("badlock_drive", 32'(kp.row_drive_o), 32'h0);
      kp.row_locked_i = 1'b0;
      n = 0;
      while (n < 10 && kp.row_drive_o === 4'b0) begin step(); n++; end
      chk("wait_rescan", 32'(n < 10), 32'h1);
      chk("rescan_drive", 32'(kp.row_drive_o), 32'h1);
      kp.row_locked_i = 1'b1; kp.row_lock_i = 4'b0001;
      n = 0;
      while (n < 10 && kp.scan_state_o !== 2'b10) begin step(); n++; end
      chk("wait_hold3", 32'(n < 10), 32'h1);
      reset = 1'b1;
      step();
      chk("midrst_state", 32'(kp.scan_state_o), 32'h0);
      chk("midrst_drive", 32'(kp.row_drive_o), 32'h0);
      chk("midrst_tick", 32'(kp.tick_o), 32'h0);
      reset = 1'b0; kp.row_locked_i = 1'b0;
      step(); step(); step();
      chk("midrst_cnt_pre", 32'(kp.tick_o), 32'h0);
      step();
      chk("midrst_cnt_tick", 32'(kp.tick_o), 32'h1);
      kp.col_n_i = 4'b0111;
      step();
`ifdef KEYPAD_SCAN_SYNC_EN
      chk("sync_stage1", 32'(kp.row_col_o[3:0]), 32'h0);
      step();
`endif
      chk("col_latency", 32'(kp.row_col_o[3:0]), 32'h8);
      for (int i = 0; i < 800; i++) begin
         r = $urandom_range(0, 99);
         kp.col_n_i = r < 70 ? 4'hF : 4'($urandom);
         if ($urandom_range(0, 15) == 0) kp.row_locked_i = ~kp.row_locked_i;
         if ($urandom_range(0, 7) == 0) begin
            sel = $urandom_range(0, 9);
            kp.row_lock_i = sel < 8 ? 4'b0001 << sel[1:0] : 4'($urandom);
         end
         reset = $urandom_range(0, 199) == 0;
         step();
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
